ws2812_encoder: RTL and testbench

- Transmit side of the WS2812 single-wire link; the counterpart to the pipeline's high-cycle decoder.
- Accepts 24-bit GRB pixel words over a valid/ready handshake and serialises them MSB-first as timed high/low pulses on o_dout.
- Appends the latch/reset low period after the last pixel of a frame.
- Sits between the frame buffer reader and the LED output pin. Its cycle counts match the decoder's T0H/T1H windows at the same clock.

---
 rtl/ws2812_encoder_if.sv | 18 +
 rtl/ws2812_encoder.sv | 154 +++++++++++++++
 tb/tb_ws2812_encoder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_encoder_if.sv
// ---------------------------------------------------------------------------
// ws2812_encoder_if
// Pixel stream handshake between the frame buffer reader (master) and the
// WS2812 encoder (slave).
//   i_pixel  [23:0]  GRB pixel word, bit 23 transmitted first
//   i_last           final pixel of a frame, qualified by i_valid
//   i_valid          pixel available
//   o_ready          encoder accepts a pixel this cycle
// ---------------------------------------------------------------------------
interface ws2812_encoder_if;
   logic [23:0] i_pixel;
   logic        i_last;
   logic        i_valid;
   logic        o_ready;

   modport master (output i_pixel, output i_last, output i_valid, input o_ready);
   modport slave  (input i_pixel, input i_last, input i_valid, output o_ready);
endinterface

// File: rtl/ws2812_encoder.sv
// ---------------------------------------------------------------------------
// ws2812_encoder
// Serialises 24-bit GRB pixels MSB-first onto the WS2812 single-wire line as
// timed high/low pulses, and appends the latch low period after the last
// pixel of a frame.
// Ports:
//   i_clk       clock
//   i_reset     synchronous, active-high reset
//   bus         ws2812_encoder_if.slave (i_pixel, i_last, i_valid, o_ready)
//   o_dout      registered serial line to the LEDs
//   o_busy      encoder is not idle
//   o_underrun  one-cycle pulse when a non-last pixel ends with no successor
// Optional feature macro: ENCODER_UNDERRUN_EN
//   defined   : underrun pulses o_underrun and forces a latch (RESET) period
//   undefined : o_underrun tied 0, underrun returns straight to IDLE
// ---------------------------------------------------------------------------
module ws2812_encoder #(
   parameter int T0H_CYCLES    = 20,
   parameter int T0L_CYCLES    = 42,
   parameter int T1H_CYCLES    = 40,
   parameter int T1L_CYCLES    = 22,
   parameter int TRESET_CYCLES = 3000,
   parameter int CNT_WIDTH     = 12
) (
   input  logic               i_clk,
   input  logic               i_reset,
   ws2812_encoder_if.slave    bus,
   output logic               o_dout,
   output logic               o_busy,
   output logic               o_underrun
);

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_RESET} state_t;

   state_t               r_state, w_state_nxt;
   logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [4:0]           r_idx, w_idx_nxt;
   logic [23:0]          r_shift, w_shift_nxt;
   logic                 r_last, w_last_nxt;
   logic                 r_dout;
   logic                 w_ready;
`ifdef ENCODER_UNDERRUN_EN
   logic                 w_underrun;
`endif

   // Phase lengths are loaded as count-1 so the phase ends on the cycle the
   // counter reads zero.
   function automatic logic [CNT_WIDTH-1:0] high_len(input logic b);
      return b ? CNT_WIDTH'(T1H_CYCLES - 1) : CNT_WIDTH'(T0H_CYCLES - 1);
   endfunction

   function automatic logic [CNT_WIDTH-1:0] low_len(input logic b);
      return b ? CNT_WIDTH'(T1L_CYCLES - 1) : CNT_WIDTH'(T0L_CYCLES - 1);
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_last_nxt  = r_last;
      w_ready     = 1'b0;
`ifdef ENCODER_UNDERRUN_EN
      w_underrun  = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.i_valid) begin
               w_state_nxt = S_HIGH;
               w_shift_nxt = bus.i_pixel;
               w_last_nxt  = bus.i_last;
               w_idx_nxt   = 5'd23;
               w_cnt_nxt   = high_len(bus.i_pixel[23]);
            end
         end
         S_HIGH: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_LOW;
               w_cnt_nxt   = low_len(r_shift[23]);
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_LOW: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (r_idx != 5'd0) begin
               // Next bit of the same pixel: its value is at [22] before the shift.
               w_state_nxt = S_HIGH;
               w_shift_nxt = {r_shift[22:0], 1'b0};
               w_idx_nxt   = r_idx - 5'd1;
               w_cnt_nxt   = high_len(r_shift[22]);
            end else if (r_last) begin
               w_state_nxt = S_RESET;
               w_cnt_nxt   = CNT_WIDTH'(TRESET_CYCLES - 1);
            end else begin
               // Final cycle of a non-last pixel: the successor must be taken
               // now to keep the bit stream gap-free.
               w_ready = 1'b1;
               if (bus.i_valid) begin
                  w_state_nxt = S_HIGH;
                  w_shift_nxt = bus.i_pixel;
                  w_last_nxt  = bus.i_last;
                  w_idx_nxt   = 5'd23;
                  w_cnt_nxt   = high_len(bus.i_pixel[23]);
               end else begin
`ifdef ENCODER_UNDERRUN_EN
                  w_underrun  = 1'b1;
                  w_state_nxt = S_RESET;
                  w_cnt_nxt   = CNT_WIDTH'(TRESET_CYCLES - 1);
`else
                  w_state_nxt = S_IDLE;
`endif
               end
            end
         end
         S_RESET: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The line is registered from the next state so o_dout rises on the first
   // cycle of HIGH, one cycle after the accepting edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_dout  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dout  <= (w_state_nxt == S_HIGH);
      end
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_last  <= w_last_nxt;
   end

   assign bus.o_ready = w_ready & ~i_reset;
   assign o_dout      = r_dout;
   assign o_busy      = (r_state != S_IDLE);
`ifdef ENCODER_UNDERRUN_EN
   assign o_underrun  = w_underrun & ~i_reset;
`else
   assign o_underrun  = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_encoder.sv
module tb_ws2812_encoder;
   logic clk = 1'b0;
   logic rst;
   logic dout, busy, underrun;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;

   ws2812_encoder_if ifc ();

   ws2812_encoder dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .bus        (ifc.slave),
      .o_dout     (dout),
      .o_busy     (busy),
      .o_underrun (underrun)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called on the first high cycle of pixel px. Measures every bit's high and
   // low run, decodes the pixel from the high widths, and for a non-last pixel
   // checks the successor is taken exactly on the final low cycle, then
   // presents the following word (nv/npx/nlast). For a last pixel it waits for
   // o_ready and checks the latch length.
   task automatic measure_pixel(input logic [23:0] px, input logic lst, input logic nv,
                                input logic [23:0] npx, input logic nlast, input string tag);
      int          hi, lo, exp_hi, exp_lo, rdy_bad, rdy_pos, dbad;
      logic [23:0] dec;
      logic        rdy, vld;
      rdy_bad = 0;
      rdy_pos = -1;
      dec     = '0;
      for (int b = 23; b >= 0; b--) begin
         exp_hi = px[b] ? 40 : 20;
         exp_lo = px[b] ? 22 : 42;
         hi = 0;
         while (dout === 1'b1 && hi < 200) begin
            if (ifc.o_ready !== 1'b0) rdy_bad++;
            hi++;
            step();
         end
         check($sformatf("%s bit%0d high", tag, b), hi, exp_hi);
         dec = {dec[22:0], (hi > 30)};
         lo = 0;
         if (b > 0) begin
            while (dout === 1'b0 && lo < 200) begin
               if (ifc.o_ready !== 1'b0) rdy_bad++;
               lo++;
               step();
            end
            check($sformatf("%s bit%0d low", tag, b), lo, exp_lo);
         end else if (!lst) begin
            while (dout === 1'b0 && lo < 200) begin
               rdy = ifc.o_ready;
               vld = ifc.i_valid;
               lo++;
               if (rdy === 1'b1) begin
                  if (rdy_pos < 0) rdy_pos = lo;
                  else rdy_bad++;
               end
               step();
               if (rdy === 1'b1 && vld === 1'b1) begin
                  ifc.i_valid = nv;
                  ifc.i_pixel = npx;
                  ifc.i_last  = nlast;
               end
            end
            check($sformatf("%s bit0 low", tag), lo, exp_lo);
            check($sformatf("%s ready position", tag), rdy_pos, exp_lo);
         end else begin
            dbad = 0;
            while (ifc.o_ready !== 1'b1 && lo < 4000) begin
               if (dout !== 1'b0 || busy !== 1'b1) dbad++;
               lo++;
               step();
            end
            check($sformatf("%s bit0 low+latch", tag), lo, exp_lo + 3000);
            check($sformatf("%s latch line/busy", tag), dbad, 0);
            check($sformatf("%s busy after latch", tag), busy, 0);
         end
      end
      check($sformatf("%s ready while busy", tag), rdy_bad, 0);
      check($sformatf("%s decoded", tag), dec, px);
   endtask

   initial begin
      logic [23:0] rpx [8];
      int          t0, hits, pos;

      rst         = 1'b1;
      ifc.i_valid = 1'b0;
      ifc.i_pixel = '0;
      ifc.i_last  = 1'b0;
      step(); step(); step();
      check("reset ready", ifc.o_ready, 0);
      check("reset dout", dout, 0);
      check("reset busy", busy, 0);
      check("reset underrun", underrun, 0);
      rst = 1'b0;
      #1;
      check("idle ready", ifc.o_ready, 1);
      check("idle busy", busy, 0);

      // Single last pixel 0xA50000 followed by the latch
      ifc.i_pixel = 24'hA50000;
      ifc.i_last  = 1'b1;
      ifc.i_valid = 1'b1;
      t0 = cyc;
      step();
      ifc.i_valid = 1'b0;
      check("t1 first high latency", dout, 1);
      check("t1 busy", busy, 1);
      measure_pixel(24'hA50000, 1'b1, 1'b0, 24'h0, 1'b0, "t1");
      check("t1 ready return cycle", cyc - t0, 4489);

      // Back-to-back 0xFFFFFF then last 0x000000, valid held
      ifc.i_pixel = 24'hFFFFFF;
      ifc.i_last  = 1'b0;
      ifc.i_valid = 1'b1;
      step();
      ifc.i_pixel = 24'h000000;
      ifc.i_last  = 1'b1;
      measure_pixel(24'hFFFFFF, 1'b0, 1'b0, 24'h0, 1'b0, "t2a");
      measure_pixel(24'h000000, 1'b1, 1'b0, 24'h0, 1'b0, "t2b");

      // Backpressure: 0x800000 with the next word held valid throughout
      ifc.i_pixel = 24'h800000;
      ifc.i_last  = 1'b0;
      ifc.i_valid = 1'b1;
      step();
      ifc.i_pixel = 24'h123456;
      ifc.i_last  = 1'b1;
      measure_pixel(24'h800000, 1'b0, 1'b0, 24'h0, 1'b0, "t3a");
      measure_pixel(24'h123456, 1'b1, 1'b0, 24'h0, 1'b0, "t3b");

      // Underrun: non-last 0x000001 with no successor
      ifc.i_pixel = 24'h000001;
      ifc.i_last  = 1'b0;
      ifc.i_valid = 1'b1;
      step();
      ifc.i_valid = 1'b0;
      hits = 0;
      pos  = 0;
      for (int k = 1; k <= 1488; k++) begin
         if (underrun === 1'b1) begin
            hits++;
            pos = k;
         end
         if (k < 1488) step();
      end
      check("t4 ready on final low", ifc.o_ready, 1);
      check("t4 dout final low", dout, 0);
`ifdef ENCODER_UNDERRUN_EN
      check("t4 underrun pulses", hits, 1);
      check("t4 underrun position", pos, 1488);
      step();
      check("t4 busy in latch", busy, 1);
      check("t4 underrun cleared", underrun, 0);
      hits = 0;
      while (ifc.o_ready !== 1'b1 && hits < 4000) begin
         if (dout !== 1'b0) hits = 5000;
         hits++;
         step();
      end
      check("t4 latch length", hits, 3000);
`else
      check("t4 underrun pulses", hits, 0);
      step();
      check("t4 busy after underrun", busy, 0);
      check("t4 ready after underrun", ifc.o_ready, 1);
      check("t4 dout after underrun", dout, 0);
`endif

      // Reset at cycle 10 of a T1H phase
      ifc.i_pixel = 24'h800000;
      ifc.i_last  = 1'b0;
      ifc.i_valid = 1'b1;
      step();
      ifc.i_valid = 1'b0;
      for (int k = 0; k < 9; k++) step();
      check("t5 dout mid-high", dout, 1);
      rst = 1'b1;
      #1;
      check("t5 ready in reset", ifc.o_ready, 0);
      step();
      check("t5 dout after reset", dout, 0);
      check("t5 busy after reset", busy, 0);
      rst = 1'b0;
      #1;
      check("t5 ready after release", ifc.o_ready, 1);
      ifc.i_pixel = 24'h0F0F0F;
      ifc.i_last  = 1'b1;
      ifc.i_valid = 1'b1;
      step();
      ifc.i_valid = 1'b0;
      check("t5 first high", dout, 1);
      measure_pixel(24'h0F0F0F, 1'b1, 1'b0, 24'h0, 1'b0, "t5");

      // Loopback decode of 8 random pixels in one frame
      for (int i = 0; i < 8; i++) rpx[i] = 24'($urandom);
      ifc.i_pixel = rpx[0];
      ifc.i_last  = 1'b0;
      ifc.i_valid = 1'b1;
      step();
      ifc.i_pixel = rpx[1];
      ifc.i_last  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i + 2 <= 7)
            measure_pixel(rpx[i], 1'b0, 1'b1, rpx[i+2], (i + 2 == 7), $sformatf("t6p%0d", i));
         else if (i == 6)
            measure_pixel(rpx[i], 1'b0, 1'b0, 24'h0, 1'b0, "t6p6");
         else
            measure_pixel(rpx[i], 1'b1, 1'b0, 24'h0, 1'b0, "t6p7");
      end
      ifc.i_last = 1'b0;
      ifc.i_pixel = rpx[7];
      check("t6 valid dropped", ifc.i_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
